// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Command-driven up/down counter sequencer with prescaler, pause,
//            abort and continuous reload.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_mode,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int                 c_psc_w    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_end;
  logic               r_dir;
  logic               r_mode;
  logic [c_psc_w-1:0] r_psc;
  logic               r_busy;
  logic               r_done;

  logic               w_tick;
  logic [WIDTH-1:0]   w_step;

  assign w_tick = (r_psc == c_psc_last);
  // Natural modulo-2^WIDTH arithmetic gives the wrap in both directions.
  assign w_step = r_dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

  assign cmd_ready = rst && (r_state == S_IDLE);
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_psc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_start <= cmd_start;
            r_end   <= cmd_end;
            r_dir   <= cmd_dir;
            r_mode  <= cmd_mode;
            r_count <= cmd_start;
            r_psc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (pause) begin
            r_state <= S_PAUSE;
          end else if (w_tick) begin
            r_psc <= '0;
            if (r_count == r_end) begin
              if (r_mode) begin
                r_count <= r_start;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_count <= w_step;
            end
          end else begin
            r_psc <= r_psc + c_psc_w'(1);
          end
        end
        S_PAUSE: begin
          // Prescaler stays frozen; the return edge itself does not advance it.
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!pause) begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequencer
// Purpose  : Randomized + directed bench for counter_sequencer (DIV=1 and DIV=4)
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_start = '0;
  logic [3:0] cmd_end = '0;
  logic       cmd_mode = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic       ready1, busy1, done1, ready4, busy4, done4;
  logic [3:0] count1, count4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 -> DIV=1, index 1 -> DIV=4
  int m_div [2] = '{1, 4};
  int m_cnt [2];
  int m_phase [2];
  int m_start [2];
  int m_end [2];
  int m_up [2];
  int m_cont [2];
  bit m_active [2];
  bit m_paused [2];
  bit m_done [2];

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_dir(cmd_dir), .cmd_start(cmd_start), .cmd_end(cmd_end),
    .cmd_mode(cmd_mode), .pause(pause), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  counter_sequencer #(.WIDTH(4), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready4),
    .cmd_dir(cmd_dir), .cmd_start(cmd_start), .cmd_end(cmd_end),
    .cmd_mode(cmd_mode), .pause(pause), .abort(abort),
    .count(count4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock edge of sequencing behaviour for instance k, using current inputs.
  task automatic model_step(input int k);
    if (!rst) begin
      m_cnt[k] = 0; m_phase[k] = 0;
      m_active[k] = 0; m_paused[k] = 0; m_done[k] = 0;
    end else if (m_done[k]) begin
      m_done[k] = 0;
    end else if (!m_active[k]) begin
      if (cmd_valid) begin
        m_start[k] = cmd_start; m_end[k] = cmd_end;
        m_up[k] = cmd_dir; m_cont[k] = cmd_mode;
        m_cnt[k] = cmd_start; m_phase[k] = 0;
        m_active[k] = 1; m_paused[k] = 0;
      end
    end else if (abort) begin
      m_active[k] = 0; m_paused[k] = 0;
    end else if (m_paused[k]) begin
      m_paused[k] = pause;
    end else if (pause) begin
      m_paused[k] = 1;
    end else begin
      m_phase[k] = m_phase[k] + 1;
      if (m_phase[k] == m_div[k]) begin
        m_phase[k] = 0;
        if (m_cnt[k] == m_end[k]) begin
          if (m_cont[k] != 0) m_cnt[k] = m_start[k];
          else begin m_active[k] = 0; m_done[k] = 1; end
        end else begin
          m_cnt[k] = (m_up[k] != 0) ? (m_cnt[k] + 1) % 16 : (m_cnt[k] + 15) % 16;
        end
      end
    end
  endtask

  task automatic check_all();
    check("d1_count", int'(count1), m_cnt[0]);
    check("d1_busy",  int'(busy1),  int'(m_active[0]));
    check("d1_done",  int'(done1),  int'(m_done[0]));
    check("d1_ready", int'(ready1), int'(rst && !m_active[0] && !m_done[0]));
    check("d4_count", int'(count4), m_cnt[1]);
    check("d4_busy",  int'(busy4),  int'(m_active[1]));
    check("d4_done",  int'(done4),  int'(m_done[1]));
    check("d4_ready", int'(ready4), int'(rst && !m_active[1] && !m_done[1]));
  endtask

  // Inputs are set before the call; both DUTs and the model see them at the edge.
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input bit dir, input int st, input int en, input bit mode);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_start = 4'(st); cmd_end = 4'(en); cmd_mode = mode;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();

    issue(1'b1, 3, 6, 1'b0);
    repeat (30) step();

    issue(1'b0, 1, 14, 1'b0);
    repeat (24) step();

    issue(1'b1, 2, 4, 1'b1);
    repeat (9) step();
    abort = 1'b1; step(); abort = 1'b0;
    repeat (3) step();

    issue(1'b1, 0, 15, 1'b0);
    repeat (3) step();
    pause = 1'b1; repeat (5) step(); pause = 1'b0;
    repeat (12) step();

    // Command activity while running must be ignored, then reset mid-run.
    issue(1'b1, 5, 12, 1'b1);
    cmd_valid = 1'b1; cmd_start = 4'd9; cmd_end = 4'd9; cmd_dir = 1'b0;
    repeat (6) step();
    cmd_valid = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    step();

    issue(1'b1, 9, 9, 1'b0);
    repeat (8) step();

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_start = 4'($urandom_range(0, 15));
      cmd_end   = ($urandom_range(0, 7) == 0) ? cmd_start : 4'($urandom_range(0, 15));
      cmd_mode  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      abort     = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
